// File: rtl/image_proc_pkg.sv
// Shared constants and state type for the image processing pipeline.
package image_proc_pkg;

  localparam int COLOR_SIZE     = 8;
  localparam int PIXEL_SIZE     = 4 * COLOR_SIZE;
  localparam int TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/feeder_skid_fifo.sv
// Two-entry skid FIFO absorbing RAM read data while the consumer stalls.
module feeder_skid_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_count,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/pixel_stream_feeder.sv
// Streams num_words words from a sync-read pixel RAM into the processor.
// Optional FEEDER_TIMEOUT_EN adds o_timeout and a bounded wait for proc_done.
module pixel_stream_feeder
  import image_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_num_words,
  input  logic                  i_stall,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic                  o_vld,
  output logic                  o_last_data,
  output logic [DATA_WIDTH-1:0] o_data_out,
  input  logic                  i_proc_done,
  output logic                  o_busy,
`ifdef FEEDER_TIMEOUT_EN
  output logic                  o_timeout,
`endif
  output logic                  o_finished
);

  feeder_state_e         r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_num;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic [ADDR_WIDTH-1:0] r_out_idx;
  logic                  r_inflight;
  logic                  r_vld;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_busy;
  logic                  r_finished;
`ifdef FEEDER_TIMEOUT_EN
  logic [7:0]            r_tmo_cnt;
  logic                  r_timeout;
`endif

  logic                  w_issue;
  logic                  w_push;
  logic                  w_avail;
  logic                  w_take;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_fifo_rdata;
  logic [1:0]            w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_push;
  logic                  w_fifo_pop;
  logic [2:0]            w_credit;
  logic [ADDR_WIDTH-1:0] w_last_idx;

  // Credit counts words held plus the one possibly returning, so the FIFO never overflows.
  assign w_credit   = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_issue    = (r_state == STREAM) && (r_rd_idx < r_num) && (w_credit < 3'd2);
  assign w_push     = r_inflight;
  assign w_avail    = !w_fifo_empty || w_push;
  assign w_take     = (r_state == STREAM) && !i_stall && w_avail;
  // Returning data bypasses an empty FIFO straight into the output register.
  assign w_head      = w_fifo_empty ? i_mem_rd_data : w_fifo_rdata;
  assign w_fifo_push = w_push && !(w_fifo_empty && w_take);
  assign w_fifo_pop  = w_take && !w_fifo_empty;
  assign w_last_idx  = r_num - ADDR_WIDTH'(1);

  feeder_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_fifo_push),
    .i_wdata (i_mem_rd_data),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_num      <= '0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_base <= i_base_addr;
            r_num  <= i_num_words;
            if (i_num_words != '0) begin
              r_state <= STREAM;
              r_busy  <= 1'b1;
            end else begin
              r_state    <= FINISH;
              r_finished <= 1'b1;
            end
          end
        end
        STREAM: begin
`ifdef FEEDER_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
          if (r_vld && r_last) r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
`ifdef FEEDER_TIMEOUT_EN
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
          if (i_proc_done) begin
            r_state    <= FINISH;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            r_state    <= FINISH;
            r_busy     <= 1'b0;
            r_finished <= 1'b1;
            r_timeout  <= 1'b1;
          end
`endif
        end
        FINISH: begin
          r_state    <= IDLE;
          r_finished <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
          r_timeout  <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_idx   <= '0;
      r_out_idx  <= '0;
      r_inflight <= 1'b0;
      r_vld      <= 1'b0;
      r_last     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_inflight <= w_issue;
      r_vld      <= w_take;
      r_last     <= w_take && (r_out_idx == w_last_idx);
      if (w_take) begin
        r_data    <= w_head;
        r_out_idx <= r_out_idx + 1'b1;
      end
      if (w_issue) r_rd_idx <= r_rd_idx + 1'b1;
      if ((r_state == IDLE) && i_start) begin
        r_rd_idx  <= '0;
        r_out_idx <= '0;
      end
    end
  end

  assign o_mem_rd_en = w_issue;
  assign o_mem_addr  = r_base + r_rd_idx;
  assign o_vld       = r_vld;
  assign o_last_data = r_last;
  assign o_data_out  = r_data;
  assign o_busy      = r_busy;
  assign o_finished  = r_finished;
`ifdef FEEDER_TIMEOUT_EN
  assign o_timeout   = r_timeout;
`endif

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Directed bench for pixel_stream_feeder with a word-stream scoreboard model.
module tb_pixel_stream_feeder;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_words;
  logic          stall;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          vld;
  logic          last_data;
  logic [DW-1:0] data_out;
  logic          proc_done;
  logic          busy;
  logic          finished;
`ifdef FEEDER_TIMEOUT_EN
  logic          timeout;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: the job the bench expects, and how far the DUT has progressed.
  logic [AW-1:0] m_base;
  logic [AW-1:0] m_num;
  int            rd_n;
  int            out_n;
  logic [AW-1:0] seen_addr [16];

  always #5 clk = ~clk;

  // Synchronous-read RAM: mem[a] = a.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= DW'(mem_addr);
  end

  pixel_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_base_addr   (base_addr),
    .i_num_words   (num_words),
    .i_stall       (stall),
    .o_mem_rd_en   (mem_rd_en),
    .o_mem_addr    (mem_addr),
    .i_mem_rd_data (mem_rd_data),
    .o_vld         (vld),
    .o_last_data   (last_data),
    .o_data_out    (data_out),
    .i_proc_done   (proc_done),
    .o_busy        (busy),
`ifdef FEEDER_TIMEOUT_EN
    .o_timeout     (timeout),
`endif
    .o_finished    (finished)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Word i of the job must read address base+i (wrapping) and carry that address as data.
  function automatic void model_check(input logic stalled);
    logic [AW-1:0] a;
    if (mem_rd_en) begin
      chk("rd_in_range", 64'(rd_n < int'(m_num)), 64'd1);
      a = m_base + AW'(rd_n);
      chk("rd_addr", 64'(mem_addr), 64'(a));
      if (rd_n < 16) seen_addr[rd_n] = mem_addr;
      rd_n++;
    end
    chk("last_only_final", 64'(last_data), 64'(vld && (out_n == int'(m_num) - 1)));
    if (vld) begin
      chk("vld_in_range", 64'(out_n < int'(m_num)), 64'd1);
      a = m_base + AW'(out_n);
      chk("data_order", 64'(data_out), 64'(DW'(a)));
      out_n++;
    end
    if (stalled) chk("vld_after_stall", 64'(vld), 64'd0);
  endfunction

  task automatic step();
    logic s;
    s = stall;
    @(posedge clk);
    #1;
    model_check(s);
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] n);
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    m_base    = b;
    m_num     = n;
    rd_n      = 0;
    out_n     = 0;
    step();
    start     = 1'b0;
  endtask

  task automatic finish_job();
    int k;
    k = 0;
    while (out_n < int'(m_num) && k < 200) begin
      step();
      k++;
    end
    chk("all_words", 64'(out_n), 64'(m_num));
    chk("all_reads", 64'(rd_n), 64'(m_num));
    step();
    chk("busy_wait_done", 64'(busy), 64'd1);
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
    chk("finished_pulse", 64'(finished), 64'd1);
    chk("busy_at_finish", 64'(busy), 64'd0);
    step();
    chk("finished_clear", 64'(finished), 64'd0);
  endtask

  initial begin
    logic [10:0] e_rd, e_vld, e_last, e_busy, e_fin;
    int k;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    stall = 1'b0; proc_done = 1'b0;
    m_base = '0; m_num = '0; rd_n = 0; out_n = 0;
    @(posedge clk); #1;
    step(); step();
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finished", 64'(finished), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_last", 64'(last_data), 64'd0);
    rst = 1'b0;
    step();

    // Test 1: exact cycle timing of a 4-word job from 0x10.
    e_rd   = 11'b000_0001_1110;
    e_vld  = 11'b000_0111_1000;
    e_last = 11'b000_0100_0000;
    e_busy = 11'b011_1111_1110;
    e_fin  = 11'b100_0000_0000;
    start_job(16'h0010, 16'd4);
    for (int t = 1; t <= 10; t++) begin
      chk($sformatf("t1_rd_en_T%0d", t), 64'(mem_rd_en), 64'(e_rd[t]));
      chk($sformatf("t1_vld_T%0d", t), 64'(vld), 64'(e_vld[t]));
      chk($sformatf("t1_last_T%0d", t), 64'(last_data), 64'(e_last[t]));
      chk($sformatf("t1_busy_T%0d", t), 64'(busy), 64'(e_busy[t]));
      chk($sformatf("t1_fin_T%0d", t), 64'(finished), 64'(e_fin[t]));
      if (e_rd[t]) chk("t1_addr", 64'(mem_addr), 64'h10 + 64'(t - 1));
      if (e_vld[t]) chk("t1_data", 64'(data_out), 64'h10 + 64'(t - 3));
      proc_done = (t == 9);
      step();
    end
    proc_done = 1'b0;
    chk("t1_idle_busy", 64'(busy), 64'd0);
    step();

    // Test 2: empty job finishes immediately with no traffic.
    start_job(16'h0055, 16'd0);
    chk("t2_finished", 64'(finished), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    step();
    chk("t2_finished_clear", 64'(finished), 64'd0);
    step(); step();
    chk("t2_no_reads", 64'(rd_n), 64'd0);
    chk("t2_no_words", 64'(out_n), 64'd0);

    // Test 3: 8 words with a 3-cycle stall; a stray start mid-job is ignored.
    start_job(16'h0040, 16'd8);
    start = 1'b1; base_addr = 16'h0999; num_words = 16'd2;
    step();
    start = 1'b0;
    step(); step();
    stall = 1'b1;
    step(); step(); step();
    stall = 1'b0;
    finish_job();

    // Test 4: address wrap, with early proc_done that must be ignored.
    start_job(16'hFFFE, 16'd4);
    proc_done = 1'b1;
    step(); step(); step();
    proc_done = 1'b0;
    chk("t4_busy_after_early_done", 64'(busy), 64'd1);
    finish_job();
    chk("t4_addr0", 64'(seen_addr[0]), 64'hFFFE);
    chk("t4_addr1", 64'(seen_addr[1]), 64'hFFFF);
    chk("t4_addr2", 64'(seen_addr[2]), 64'h0000);
    chk("t4_addr3", 64'(seen_addr[3]), 64'h0001);

    // Test 5: reset while the third word is on the output, then a clean job.
    start_job(16'h0100, 16'd6);
    k = 0;
    while (out_n < 3 && k < 20) begin
      step();
      k++;
    end
    chk("t5_reached_word3", 64'(out_n), 64'd3);
    rst = 1'b1;
    step();
    chk("t5_rst_vld", 64'(vld), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_fin", 64'(finished), 64'd0);
    chk("t5_rst_rd_en", 64'(mem_rd_en), 64'd0);
    rst = 1'b0;
    m_num = '0; rd_n = 0; out_n = 0;
    step();
    chk("t5_no_fin_after_rst", 64'(finished), 64'd0);
    start_job(16'h0020, 16'd3);
    finish_job();

`ifdef FEEDER_TIMEOUT_EN
    // Test 6: proc_done never arrives; timeout and finished pulse together.
    start_job(16'h0200, 16'd1);
    k = 0;
    while (!(vld && last_data) && k < 20) begin
      step();
      k++;
    end
    k = 0;
    while (!finished && k < 400) begin
      step();
      k++;
    end
    chk("t6_tmo_latency", 64'(k), 64'd256);
    chk("t6_tmo_pulse", 64'(timeout), 64'd1);
    step();
    chk("t6_tmo_clear", 64'(timeout), 64'd0);
    chk("t6_fin_clear", 64'(finished), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
